memory_sequencer: RTL and testbench
===================================

MEMORY_SEQUENCER -- requirements
Module: memory_sequencer

Interface
REQ-001 SHALL have parameter ON_CYCLES, default 4, number of cycles each entry is shown on leds (minimum 1).
REQ-002 SHALL have parameter OFF_CYCLES, default 2, number of blank cycles after each entry (minimum 1).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port play  input  1  start playback of RAM addresses 0..last; sampled only in IDLE.
REQ-006 SHALL have port last  input  4  final address to play; sampled with play.
REQ-007 SHALL have port rec_valid  input  1  append rec_data to RAM at address rec_count.
REQ-008 SHALL have port rec_data  input  4  value to record.
REQ-009 SHALL have port rec_clear  input  1  reset the record pointer to 0.
REQ-010 SHALL have ports ram_we  output  1, ram_addr  output  4, ram_data  output  4: drive a 16x4 synchronous RAM with a registered read address.
REQ-011 SHALL have port ram_q  input  4  RAM read data, valid the cycle after ram_addr is registered.
REQ-012 SHALL have ports leds  output  4 (entry being shown), busy  output  1, done  output  1 (one-cycle pulse), rec_count  output  5 (0..16), full  output  1 (rec_count==16).

Function
REQ-013 SHALL implement states IDLE, FETCH, LATCH, SHOW, GAP, DONE.
REQ-014 In IDLE, play=1 at edge k SHALL capture last, clear the play index to 0, and enter FETCH at k+1.
REQ-015 FETCH SHALL drive ram_addr=index for one cycle, then go to LATCH.
REQ-016 LATCH SHALL capture ram_q into the led register at its closing edge, then go to SHOW; leds therefore shows mem[0] from k+3.
REQ-017 SHOW SHALL last exactly ON_CYCLES cycles with leds=captured value, then go to GAP.
REQ-018 GAP SHALL last exactly OFF_CYCLES cycles with leds=0; on exit it SHALL go to FETCH with index+1 if index<last, else to DONE.
REQ-019 DONE SHALL last one cycle with done=1, then go to IDLE; done SHALL be 0 in every other state.
REQ-020 busy SHALL be 1 in every state except IDLE; leds SHALL be 0 outside SHOW.
REQ-021 last=15 SHALL play all 16 entries; the index SHALL NOT wrap or repeat address 0.
REQ-022 ram_we SHALL be 1 only in IDLE, with rec_valid=1, full=0, play=0, rec_clear=0 and reset_n=1; it is combinational and ram_addr=rec_count[3:0], ram_data=rec_data in that cycle.
REQ-023 An accepted write SHALL increment rec_count at the same edge; at rec_count=16 writes SHALL be dropped and full=1.
REQ-024 Simultaneous play and rec_valid in IDLE: play SHALL win; the write SHALL be dropped.
REQ-025 rec_valid while busy SHALL be ignored; play while busy SHALL be ignored, with no restart.
REQ-026 rec_clear SHALL set rec_count to 0 in any state and SHALL take priority over rec_valid; RAM contents SHALL be untouched.
REQ-027 Outside writes and FETCH, ram_addr SHALL hold the current play index, and ram_data SHALL be 0.

Reset
REQ-028 reset_n=0 at an edge SHALL force IDLE, leds=0, busy=0, done=0, rec_count=0, full=0 and index=0, including mid-playback.
REQ-029 ram_we SHALL be 0 in any cycle where reset_n=0; RAM contents SHALL NOT be cleared by reset.

Structure
REQ-030 The state encoding and the default ON/OFF constants SHALL live in the shared package mem_seq_pkg.
REQ-031 SHOW and GAP durations SHALL use one sub-module, interval_timer: a loadable down-counter with a zero flag, reused for both phases.
REQ-032 A single always block SHALL hold the registered state, with next-state and output logic separate; the design SHALL have no latches.

Verification
REQ-033 Record: reset, then rec_valid with data 3,7,A -> writes to addresses 0,1,2; rec_count=3; full=0.
REQ-034 Playback, defaults: RAM holds 3,7,A; play with last=2 at edge k -> leds=3 for k+3..k+6, 0 for k+7..k+8, 7 from k+11, A from k+19; done=1 at k+25; busy=1 from k+1..k+25.
REQ-035 Full: 17 rec_valid pulses -> 16 writes, 17th has ram_we=0, rec_count=16, full=1; then rec_clear -> rec_count=0, full=0.
REQ-036 Conflicts in IDLE: play and rec_valid in the same cycle -> no write, playback starts; rec_valid during SHOW -> ram_we stays 0.
REQ-037 Mid-playback reset: reset_n=0 during SHOW of entry 1 -> next cycle IDLE, leds=0, busy=0, done never pulses, rec_count=0.
REQ-038 Wrap: last=15 with RAM holding 0..F -> leds show 0..F in order, exactly 16 SHOW phases, then done.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared state encoding and default timing constants for the memory sequencer.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_SHOW  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_t;

  localparam int DEF_ON_CYCLES  = 4;
  localparam int DEF_OFF_CYCLES = 2;
  localparam int TIMER_W        = 8;

endpackage

// File: rtl/memory_sequencer_interval_timer.sv
// Loadable down-counter with a zero flag; times both the SHOW and GAP phases.
module interval_timer
  import mem_seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  output logic               zero
);

  logic [TIMER_W-1:0] count;

  // Count down to zero and hold there until reloaded.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= {TIMER_W{1'b0}};
    end else if (load) begin
      count <= load_value;
    end else if (count != {TIMER_W{1'b0}}) begin
      count <= count - {{(TIMER_W-1){1'b0}}, 1'b1};
    end
  end

  assign zero = (count == {TIMER_W{1'b0}});

endmodule

// File: rtl/memory_sequencer.sv
// Records 4-bit entries into an external 16x4 RAM and plays them back on leds
// with fixed on/off intervals.
module memory_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ON_CYCLES  = DEF_ON_CYCLES,
  parameter int OFF_CYCLES = DEF_OFF_CYCLES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       play,
  input  logic [3:0] last,
  input  logic       rec_valid,
  input  logic [3:0] rec_data,
  input  logic       rec_clear,
  output logic       ram_we,
  output logic [3:0] ram_addr,
  output logic [3:0] ram_data,
  input  logic [3:0] ram_q,
  output logic [3:0] leds,
  output logic       busy,
  output logic       done,
  output logic [4:0] rec_count,
  output logic       full
);

  localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);

  seq_state_t         state;
  seq_state_t         next_state;
  logic [3:0]         index;
  logic [3:0]         last_r;
  logic [3:0]         led_r;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_zero;

  interval_timer u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  // Next-state and timer control; the timer is loaded on the edge entering each phase.
  always_comb begin
    next_state  = state;
    timer_load  = 1'b0;
    timer_value = {TIMER_W{1'b0}};
    case (state)
      ST_IDLE: begin
        if (play) next_state = ST_FETCH;
        else      next_state = ST_IDLE;
      end
      ST_FETCH: next_state = ST_LATCH;
      ST_LATCH: begin
        next_state  = ST_SHOW;
        timer_load  = 1'b1;
        timer_value = ON_LOAD;
      end
      ST_SHOW: begin
        if (timer_zero) begin
          next_state  = ST_GAP;
          timer_load  = 1'b1;
          timer_value = OFF_LOAD;
        end else begin
          next_state = ST_SHOW;
        end
      end
      ST_GAP: begin
        if (!timer_zero)         next_state = ST_GAP;
        else if (index < last_r) next_state = ST_FETCH;
        else                     next_state = ST_DONE;
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  assign full     = (rec_count == 5'd16);
  assign ram_we   = reset_n && (state == ST_IDLE) && rec_valid && !full && !play && !rec_clear;
  assign ram_addr = ram_we ? rec_count[3:0] : index;
  assign ram_data = ram_we ? rec_data : 4'd0;
  assign leds     = (state == ST_SHOW) ? led_r : 4'd0;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

  // All sequencer registers; index stops at last so last=15 never wraps to 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      index     <= 4'd0;
      last_r    <= 4'd0;
      led_r     <= 4'd0;
      rec_count <= 5'd0;
    end else begin
      state <= next_state;
      if ((state == ST_IDLE) && play) begin
        last_r <= last;
        index  <= 4'd0;
      end else if ((state == ST_GAP) && timer_zero && (index < last_r)) begin
        index <= index + 4'd1;
      end
      if (state == ST_LATCH) led_r <= ram_q;
      if (rec_clear)   rec_count <= 5'd0;
      else if (ram_we) rec_count <= rec_count + 5'd1;
    end
  end

endmodule

// File: tb/tb_memory_sequencer.sv
// Directed bench for memory_sequencer with a behavioural 16x4 synchronous RAM.
module tb_memory_sequencer;

  logic       clk = 1'b0;
  logic       reset_n, play, rec_valid, rec_clear;
  logic [3:0] last, rec_data;
  logic       ram_we;
  logic [3:0] ram_addr, ram_data, ram_q, leds;
  logic       busy, done, full;
  logic [4:0] rec_count;

  logic [3:0] mem [16];
  logic [3:0] exp_mem [16];
  int vectors = 0;
  int miscompares = 0;

  memory_sequencer dut (
    .clk(clk), .reset_n(reset_n), .play(play), .last(last),
    .rec_valid(rec_valid), .rec_data(rec_data), .rec_clear(rec_clear),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .ram_q(ram_q),
    .leds(leds), .busy(busy), .done(done), .rec_count(rec_count), .full(full)
  );

  always #5 clk = ~clk;

  // RAM with registered read address.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives play for one cycle and checks every cycle of the playback against the timing model.
  task automatic run_play(input logic [3:0] lst, input string tag);
    int total, ph, e;
    logic [3:0] el;
    logic eb, ed;
    total = 1 + 8 * (int'(lst) + 1);
    play = 1'b1; last = lst;
    #1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL %s busy_before_play got=%b want=0", tag, busy); end
    step();
    play = 1'b0;
    for (int t = 1; t <= total + 2; t++) begin
      eb = (t <= total);
      ed = (t == total);
      el = 4'd0;
      if (t >= 3 && t < total) begin
        ph = (t - 3) % 8;
        e  = (t - 3) / 8;
        if (ph < 4) el = exp_mem[e];
      end
      vectors++;
      if (leds !== el || busy !== eb || done !== ed) begin
        miscompares++;
        $display("FAIL %s cycle=%0d leds/busy/done got=%h/%b/%b want=%h/%b/%b", tag, t, leds, busy, done, el, eb, ed);
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; play = 1'b0; last = 4'd0; rec_valid = 1'b1; rec_data = 4'd5; rec_clear = 1'b0;
    step();
    step();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || leds !== 4'd0 || rec_count !== 5'd0 || full !== 1'b0 || ram_we !== 1'b0) begin
      miscompares++;
      $display("FAIL reset busy=%b done=%b leds=%h rec_count=%0d full=%b ram_we=%b want all 0", busy, done, leds, rec_count, full, ram_we);
    end
    rec_valid = 1'b0;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_record();
    logic [3:0] vals [3];
    vals[0] = 4'h3; vals[1] = 4'h7; vals[2] = 4'hA;
    for (int i = 0; i < 3; i++) begin
      rec_valid = 1'b1; rec_data = vals[i];
      #1;
      vectors++;
      if (ram_we !== 1'b1 || ram_addr !== 4'(i) || ram_data !== vals[i]) begin
        miscompares++;
        $display("FAIL record_write%0d we/addr/data got=%b/%h/%h want=1/%h/%h", i, ram_we, ram_addr, ram_data, 4'(i), vals[i]);
      end
      step();
      exp_mem[i] = vals[i];
    end
    rec_valid = 1'b0;
    #1;
    vectors++;
    if (rec_count !== 5'd3 || full !== 1'b0 || ram_data !== 4'd0) begin
      miscompares++;
      $display("FAIL record_count rec_count/full/ram_data got=%0d/%b/%h want=3/0/0", rec_count, full, ram_data);
    end
    vectors++;
    if (mem[0] !== 4'h3 || mem[1] !== 4'h7 || mem[2] !== 4'hA) begin
      miscompares++;
      $display("FAIL record_mem got=%h,%h,%h want=3,7,a", mem[0], mem[1], mem[2]);
    end
  endtask

  task automatic test_playback();
    run_play(4'd2, "playback");
  endtask

  task automatic test_conflict();
    play = 1'b1; last = 4'd0; rec_valid = 1'b1; rec_data = 4'hF;
    #1;
    vectors++;
    if (ram_we !== 1'b0) begin miscompares++; $display("FAIL conflict_play_wins ram_we got=%b want=0", ram_we); end
    step();
    play = 1'b0; rec_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1 || rec_count !== 5'd3) begin
      miscompares++;
      $display("FAIL conflict_start busy/rec_count got=%b/%0d want=1/3", busy, rec_count);
    end
    step(); step();
    rec_valid = 1'b1; play = 1'b1; last = 4'd5;
    #1;
    vectors++;
    if (ram_we !== 1'b0 || leds !== 4'h3) begin
      miscompares++;
      $display("FAIL conflict_show we/leds got=%b/%h want=0/3", ram_we, leds);
    end
    for (int t = 3; t < 9; t++) step();
    rec_valid = 1'b0; play = 1'b0;
    vectors++;
    if (done !== 1'b1) begin miscompares++; $display("FAIL conflict_no_restart done got=%b want=1", done); end
    step();
    vectors++;
    if (busy !== 1'b0 || rec_count !== 5'd3) begin
      miscompares++;
      $display("FAIL conflict_end busy/rec_count got=%b/%0d want=0/3", busy, rec_count);
    end
  endtask

  task automatic test_full();
    rec_clear = 1'b1; rec_valid = 1'b1;
    #1;
    vectors++;
    if (ram_we !== 1'b0) begin miscompares++; $display("FAIL clear_priority ram_we got=%b want=0", ram_we); end
    step();
    rec_clear = 1'b0;
    for (int i = 0; i < 17; i++) begin
      rec_valid = 1'b1; rec_data = 4'(i);
      #1;
      vectors++;
      if (ram_we !== (i < 16)) begin
        miscompares++;
        $display("FAIL full_write%0d ram_we got=%b want=%b", i, ram_we, (i < 16));
      end
      step();
      if (i < 16) exp_mem[i] = 4'(i);
    end
    rec_valid = 1'b0;
    vectors++;
    if (rec_count !== 5'd16 || full !== 1'b1 || mem[15] !== 4'hF) begin
      miscompares++;
      $display("FAIL full_state rec_count/full/mem15 got=%0d/%b/%h want=16/1/f", rec_count, full, mem[15]);
    end
    rec_clear = 1'b1;
    step();
    rec_clear = 1'b0;
    vectors++;
    if (rec_count !== 5'd0 || full !== 1'b0 || mem[4] !== 4'h4) begin
      miscompares++;
      $display("FAIL full_clear rec_count/full/mem4 got=%0d/%b/%h want=0/0/4", rec_count, full, mem[4]);
    end
  endtask

  task automatic test_midreset();
    rec_valid = 1'b1; rec_data = 4'h0;
    step();
    rec_valid = 1'b0;
    play = 1'b1; last = 4'd2;
    step();
    play = 1'b0;
    for (int t = 1; t < 12; t++) step();
    vectors++;
    if (leds !== 4'h1 || rec_count !== 5'd1) begin
      miscompares++;
      $display("FAIL midreset_pre leds/rec_count got=%h/%0d want=1/1", leds, rec_count);
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    vectors++;
    if (busy !== 1'b0 || leds !== 4'd0 || done !== 1'b0 || rec_count !== 5'd0) begin
      miscompares++;
      $display("FAIL midreset_post busy/leds/done/rec_count got=%b/%h/%b/%0d want=0/0/0/0", busy, leds, done, rec_count);
    end
    for (int t = 0; t < 30; t++) begin
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_quiet cycle=%0d done/busy got=%b/%b want=0/0", t, done, busy);
      end
      step();
    end
  endtask

  task automatic test_wrap();
    run_play(4'd15, "wrap");
  endtask

  initial begin
    test_reset();
    test_record();
    test_playback();
    test_conflict();
    test_full();
    test_midreset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
